// File: rtl/intr_pkg.sv
// intr_pkg: register map and FSM states shared by the interrupt controller and the CPU decoder.
package intr_pkg;
    localparam logic [3:0] INTR_ACK  = 4'd0;
    localparam logic [3:0] INTR_EN   = 4'd1;
    localparam logic [3:0] INTR_VEC  = 4'd2;
    localparam logic [3:0] INTR_MASK = 4'd3;
    localparam logic [3:0] INTR_MODE = 4'd4;
    localparam logic [3:0] INTR_SET  = 4'd5;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} intr_state_e;
endpackage

// File: rtl/intr_src_sync.sv
// intr_src_sync: 2-flop synchroniser for one interrupt line plus a rising-edge detector.
module intr_src_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;
    always_ff @(posedge clk) begin
        if (reset) {s3_q, s2_q, s1_q} <= 3'b000;
        else       {s3_q, s2_q, s1_q} <= {s2_q, s1_q, d_i};
    end
    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: N prioritised, maskable interrupt sources with a request/take/service
// handshake towards the CPU and a per-source vector.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int XLEN       = 32,
    parameter int VEC_STRIDE = 1,
    localparam int IDW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             irq_take,
    output logic             irq,
    output logic [IDW-1:0]   irq_id,
    output logic [XLEN-1:0]  irq_vec,
    output logic             intr_en,
    output logic [N_SRC-1:0] pending
);
    logic [N_SRC-1:0] sync, rise, mask_q, mode_q, pending_q, pending_d, cand, clr, set_v;
    logic [XLEN-1:0]  vec_base_q;
    logic [IDW-1:0]   id_q, win;
    logic             en_q, irq_q;
    intr_state_e      state_q;
    logic wr_ack, wr_enr, wr_vec, wr_mask, wr_mode, wr_set;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        intr_src_sync u_sync (
            .clk     (clk),
            .reset   (reset),
            .d_i     (src[g]),
            .level_o (sync[g]),
            .rise_o  (rise[g])
        );
    end

    assign wr_ack  = wr_en && wr_addr == INTR_ACK;
    assign wr_enr  = wr_en && wr_addr == INTR_EN;
    assign wr_vec  = wr_en && wr_addr == INTR_VEC;
    assign wr_mask = wr_en && wr_addr == INTR_MASK;
    assign wr_mode = wr_en && wr_addr == INTR_MODE;
    assign wr_set  = wr_en && wr_addr == INTR_SET;

    assign cand  = pending_q & mask_q;
    assign clr   = (state_q == SERVICE && wr_ack) ? (N_SRC'(1) << id_q) : '0;
    assign set_v = (mode_q & rise) | (~mode_q & sync) | (wr_set ? wr_data[N_SRC-1:0] : '0);
    // set after clear so an edge landing on the ack cycle is kept
    assign pending_d = (pending_q & ~clr) | set_v;

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) if (cand[i]) win = IDW'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            id_q       <= '0;
            en_q       <= 1'b0;
            vec_base_q <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            pending_q  <= '0;
        end else begin
            pending_q <= pending_d;
            if (wr_vec)  vec_base_q <= wr_data;
            if (wr_mask) mask_q     <= wr_data[N_SRC-1:0];
            if (wr_mode) mode_q     <= wr_data[N_SRC-1:0];
            if (state_q == REQ && irq_take) en_q <= 1'b0;
            else if (wr_enr)                en_q <= wr_data[0];
            case (state_q)
                IDLE: if (en_q && |cand) begin
                    id_q    <= win;
                    irq_q   <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (irq_take) begin
                    irq_q   <= 1'b0;
                    state_q <= SERVICE;
                end else if (wr_enr && !wr_data[0]) begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
                SERVICE: if (wr_ack) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq     = irq_q;
    assign irq_id  = id_q;
    assign irq_vec = vec_base_q + XLEN'(id_q) * XLEN'(VEC_STRIDE);
    assign intr_en = en_q;
    assign pending = pending_q;
endmodule
